// File: rtl/mips_sc_run_controller_if.sv
// Bundle of run-control pulses, instruction/flag inputs and datapath control
// outputs shared between the MIPS run controller and its datapath/host.
interface mips_sc_run_controller_if #(
    parameter int CNT_W = 16
);
    logic             start;
    logic             stop;
    logic             step;
    logic [31:0]      instruction;
    logic             zeroflag;

    logic             ldinpc;
    logic             initpc;
    logic             JumpSrc;
    logic             PCsignal;
    logic             RegDst;
    logic             WriteSrc;
    logic             RegWSrc;
    logic             RegWrite;
    logic             ALUSrc;
    logic             MemRead;
    logic             MemWrite;
    logic             PCSrc;
    logic             MemtoReg;
    logic [2:0]       ALUoperation;
    logic             busy;
    logic             halted;
    logic             err;
    logic [CNT_W-1:0] retired;

    modport master (
        output start, stop, step, instruction, zeroflag,
        input  ldinpc, initpc, JumpSrc, PCsignal, RegDst, WriteSrc, RegWSrc,
               RegWrite, ALUSrc, MemRead, MemWrite, PCSrc, MemtoReg,
               ALUoperation, busy, halted, err, retired
    );

    modport slave (
        input  start, stop, step, instruction, zeroflag,
        output ldinpc, initpc, JumpSrc, PCsignal, RegDst, WriteSrc, RegWSrc,
               RegWrite, ALUSrc, MemRead, MemWrite, PCSrc, MemtoReg,
               ALUoperation, busy, halted, err, retired
    );
endinterface

// File: rtl/mips_sc_run_controller.sv
// Single-cycle MIPS control decoder plus run sequencer (start/stop/step/halt/budget).
// Optional illegal-instruction trap enabled by defining MIPS_CTRL_ILLEGAL_TRAP_EN.
module mips_sc_run_controller #(
    parameter int         CNT_W     = 16,
    parameter int         MAX_INSTR = 0,
    parameter logic [5:0] HALT_OP   = 6'h3F
) (
    input logic                   clk,
    input logic                   rst,
    mips_sc_run_controller_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_INIT, S_RUN, S_PAUSE, S_STEP, S_HALT
    } state_t;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;
    localparam logic [CNT_W-1:0] BUDGET = CNT_W'(MAX_INSTR);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] retired_q;
    logic             err_q;

    logic [5:0] op, funct;
    logic       legal, is_halt, halt_like, exec_st, execute, budget_hit;
    logic       d_jumpsrc, d_pcsignal, d_regdst, d_writesrc, d_regwsrc, d_regwrite;
    logic       d_alusrc, d_memread, d_memwrite, d_pcsrc, d_memtoreg;
    logic [2:0] d_aluop;
    logic       unused_bits;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign op          = bus.instruction[31:26];
    assign funct       = bus.instruction[5:0];
    assign unused_bits = ^bus.instruction[25:6];

    always_comb begin
        legal      = 1'b0;
        d_jumpsrc  = 1'b0;
        d_pcsignal = 1'b0;
        d_regdst   = 1'b0;
        d_writesrc = 1'b0;
        d_regwsrc  = 1'b0;
        d_regwrite = 1'b0;
        d_alusrc   = 1'b0;
        d_memread  = 1'b0;
        d_memwrite = 1'b0;
        d_pcsrc    = 1'b0;
        d_memtoreg = 1'b0;
        d_aluop    = ALU_AND;
        case (op)
            6'h00: begin
                case (funct)
                    6'h20, 6'h22, 6'h24, 6'h25, 6'h2A: begin
                        legal      = 1'b1;
                        d_regdst   = 1'b1;
                        d_regwrite = 1'b1;
                        case (funct)
                            6'h20:   d_aluop = ALU_ADD;
                            6'h22:   d_aluop = ALU_SUB;
                            6'h24:   d_aluop = ALU_AND;
                            6'h25:   d_aluop = ALU_OR;
                            default: d_aluop = ALU_SLT;
                        endcase
                    end
                    6'h08: begin
                        legal      = 1'b1;
                        d_pcsignal = 1'b1;
                    end
                    default: legal = 1'b0;
                endcase
            end
            6'h23: begin
                legal      = 1'b1;
                d_alusrc   = 1'b1;
                d_aluop    = ALU_ADD;
                d_memread  = 1'b1;
                d_memtoreg = 1'b1;
                d_regwrite = 1'b1;
            end
            6'h2B: begin
                legal      = 1'b1;
                d_alusrc   = 1'b1;
                d_aluop    = ALU_ADD;
                d_memwrite = 1'b1;
            end
            6'h04: begin
                legal   = 1'b1;
                d_aluop = ALU_SUB;
                d_pcsrc = bus.zeroflag;
            end
            6'h08, 6'h0A: begin
                legal      = 1'b1;
                d_alusrc   = 1'b1;
                d_regwrite = 1'b1;
                d_aluop    = (op == 6'h08) ? ALU_ADD : ALU_SLT;
            end
            6'h02, 6'h03: begin
                legal      = 1'b1;
                d_pcsignal = 1'b1;
                d_jumpsrc  = 1'b1;
                d_regwsrc  = (op == 6'h03);
                d_writesrc = (op == 6'h03);
                d_regwrite = (op == 6'h03);
            end
            default: legal = 1'b0;
        endcase
    end

    // Halt-like instructions stop the sequencer without loading the PC or retiring.
    assign is_halt = (op == HALT_OP);
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
    assign halt_like = is_halt || !legal;
`else
    assign halt_like = is_halt;
`endif
    assign exec_st    = (state == S_RUN) || (state == S_STEP);
    assign execute    = exec_st && !halt_like;
    assign budget_hit = (MAX_INSTR != 0) && (sat_inc(retired_q) == BUDGET);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            retired_q <= '0;
            err_q     <= 1'b0;
        end else if (state == S_INIT) begin
            retired_q <= '0;
            err_q     <= 1'b0;
        end else begin
            if (execute) retired_q <= sat_inc(retired_q);
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
            if (exec_st && !is_halt && !legal) err_q <= 1'b1;
`endif
        end
    end

    always_comb begin
        state_nxt        = state;
        bus.ldinpc       = 1'b0;
        bus.initpc       = 1'b0;
        bus.JumpSrc      = 1'b0;
        bus.PCsignal     = 1'b0;
        bus.RegDst       = 1'b0;
        bus.WriteSrc     = 1'b0;
        bus.RegWSrc      = 1'b0;
        bus.RegWrite     = 1'b0;
        bus.ALUSrc       = 1'b0;
        bus.MemRead      = 1'b0;
        bus.MemWrite     = 1'b0;
        bus.PCSrc        = 1'b0;
        bus.MemtoReg     = 1'b0;
        bus.ALUoperation = 3'b000;
        case (state)
            S_IDLE:  if (bus.start) state_nxt = S_INIT;
            S_INIT: begin
                bus.initpc = 1'b1;
                state_nxt  = S_RUN;
            end
            S_RUN, S_STEP: begin
                if (halt_like) begin
                    state_nxt = S_HALT;
                end else begin
                    bus.ldinpc       = 1'b1;
                    bus.JumpSrc      = d_jumpsrc;
                    bus.PCsignal     = d_pcsignal;
                    bus.RegDst       = d_regdst;
                    bus.WriteSrc     = d_writesrc;
                    bus.RegWSrc      = d_regwsrc;
                    bus.RegWrite     = d_regwrite;
                    bus.ALUSrc       = d_alusrc;
                    bus.MemRead      = d_memread;
                    bus.MemWrite     = d_memwrite;
                    bus.PCSrc        = d_pcsrc;
                    bus.MemtoReg     = d_memtoreg;
                    bus.ALUoperation = d_aluop;
                    if (budget_hit)              state_nxt = S_HALT;
                    else if (state == S_STEP)    state_nxt = S_PAUSE;
                    else if (bus.stop)           state_nxt = S_PAUSE;
                end
            end
            S_PAUSE: begin
                if (bus.start)     state_nxt = S_RUN;
                else if (bus.step) state_nxt = S_STEP;
            end
            S_HALT:  if (bus.start) state_nxt = S_INIT;
            default: state_nxt = S_IDLE;
        endcase
    end

    assign bus.busy    = (state == S_INIT) || exec_st;
    assign bus.halted  = (state == S_HALT);
    assign bus.err     = err_q;
    assign bus.retired = retired_q;
endmodule

// File: doc/mips_sc_run_controller.md
Name: mips_sc_run_controller

Overview:
- Control unit and run sequencer for the single-cycle MIPS datapath.
- Decodes the current instruction (opcode/funct) combinationally into every datapath control line. The datapath then executes it in the same cycle.
- A run-control FSM gates all architectural writes and PC loads, and provides start, pause, single-step, halt-opcode and instruction-budget control.
- Sits beside the datapath; start/stop/step come from the testbench or a debug host.

Parameters:
- CNT_W, 16, width of the retired-instruction counter.
- MAX_INSTR, 0, instruction budget. 0 means unlimited; otherwise the FSM halts after this many retirements.
- HALT_OP, 6'h3F, opcode that halts execution.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  pulse: IDLE/HALT -> INIT; PAUSE -> RUN.
- stop  input  1  pulse: RUN -> PAUSE.
- step  input  1  pulse: PAUSE -> STEP (exactly one instruction).
- instruction  input  32  current instruction from instruction memory.
- zeroflag  input  1  ALU zero flag.
- ldinpc, initpc, JumpSrc, PCsignal, RegDst, WriteSrc, RegWSrc, RegWrite, ALUSrc, MemRead, MemWrite, PCSrc, MemtoReg  output  1 each  datapath controls.
- ALUoperation  output  3  ALU op: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT.
- busy  output  1  high in INIT/RUN/STEP.
- halted  output  1  high in HALT.
- err  output  1  sticky illegal-instruction flag.
- retired  output  CNT_W  count of instructions executed since the last INIT.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, retired=0, err=0. All outputs are 0.
- States and transitions:
  - IDLE: start -> INIT.
  - INIT: lasts 1 cycle. initpc=1, ldinpc=0, no writes. Clears retired and err. Next state RUN.
  - RUN: executes one instruction per cycle. stop -> PAUSE. stop wins over a simultaneous start. The instruction in the cycle where stop is sampled still executes.
  - PAUSE: no PC load, no writes. start -> RUN. step -> STEP. start wins over step.
  - STEP: executes one instruction, then returns to PAUSE.
  - HALT: start -> INIT. No other exit except reset.
- Execute cycle (RUN or STEP with a legal, non-halt opcode):
  - ldinpc=1; decoded controls are driven; retired increments, saturating at all-ones.
- In any non-execute state: ldinpc, RegWrite, MemWrite and MemRead are 0. Other controls are don't-care and are driven 0.
- Decode (mux selects: 0 = first input):
  - R-type (op 0):
    - add 0x20, sub 0x22, and 0x24, or 0x25, slt 0x2A: RegDst=1, RegWrite=1, ALU op per funct.
    - jr 0x08: PCsignal=1, JumpSrc=0, no write.
  - lw 0x23: ALUSrc=1, ADD, MemRead=1, MemtoReg=1, RegWrite=1.
  - sw 0x2B: ALUSrc=1, ADD, MemWrite=1.
  - beq 0x04: SUB, PCSrc=zeroflag.
  - addi 0x08: ALUSrc=1, ADD, RegWrite=1.
  - slti 0x0A: ALUSrc=1, SLT, RegWrite=1.
  - j 0x02: PCsignal=1, JumpSrc=1.
  - jal 0x03: as j, plus RegWSrc=1, WriteSrc=1, RegWrite=1.
- HALT_OP during RUN/STEP: ldinpc=0, no writes, not retired, next state HALT.
- Budget (MAX_INSTR != 0): an execute cycle that brings retired to MAX_INSTR goes to HALT instead of RUN/PAUSE. That instruction is fully executed.
- Reset asserted mid-RUN: immediate return to IDLE, outputs 0 in the same instant.

Optional Feature:
- Macro: MIPS_CTRL_ILLEGAL_TRAP_EN.
- Defined: an unknown opcode, or unknown funct with op 0, is treated like HALT_OP (no PC load, no writes, not retired) and additionally sets err=1. err is cleared by INIT or reset.
- Undefined: an illegal instruction executes as a NOP (ldinpc=1, pc+4, no writes, retired increments) and err stays 0.

Test Plan:
- Reset low, then release, no start -> IDLE for 10 cycles: ldinpc=0, busy=0, retired=0.
- start pulse -> next cycle initpc=1, ldinpc=0. Following cycle: instruction 0x012A4020 (add $8,$9,$10) gives RegDst=1, RegWrite=1, ALUoperation=010, ldinpc=1; retired becomes 1.
- beq 0x11090002 with zeroflag=1 -> PCSrc=1, ALUoperation=110, RegWrite=0. With zeroflag=0 -> PCSrc=0.
- jal 0x0C000010 -> PCsignal=1, JumpSrc=1, RegWSrc=1, WriteSrc=1, RegWrite=1.
- stop during RUN -> PAUSE, ldinpc=0. step -> exactly one cycle with ldinpc=1, retired +1, then PAUSE. Simultaneous start+step -> RUN.
- Instruction 0xFC000000 -> HALT next cycle, halted=1, retired unchanged. With MAX_INSTR=3: HALT after the 3rd retirement, retired=3.
